fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Initiator side of the run/ok instruction handshake; the existing decode/execute unit is the responder.
- Owns the program counter and fetches each 32-bit instruction as four bytes from the byte-wide main memory, little-endian.
- Presents the instruction with run asserted, waits for ok, applies any PC redirect from the executor, then fetches the next instruction.
- Sits between main memory's read port (read arbitration is handled upstream) and the decode/execute unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 19, width of the main-memory byte address.
- TIMEOUT_CYCLES, 64, maximum run-high cycles before fault (only used with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  level enable; low means stop at the next instruction boundary.
- MMemory_raddr  out  ADDR_W  byte read address.
- MMemory_rdata  in  8  read data, equal to mem[MMemory_raddr as registered in the previous cycle] (1-cycle latency).
- instr  out  32  assembled instruction, stable while run=1.
- run  out  1  instruction valid / execute request.
- ok  in  1  executor finished; held high until run falls.
- PC_decode_wdata  in  32  redirect target.
- PC_decode_wren  in  1  redirect strobe, may pulse any cycle while run=1.
- intr  in  1  halt request, sampled with ok.
- pc  out  32  address of the current instruction.
- halted  out  1  sequencer stopped in HALT.
- fault  out  1  watchdog expiry flag (tied 0 without the optional feature).

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, pc=RESET_PC, MMemory_raddr=0, instr=0, run=0, halted=0, fault=0, redirect latch cleared, byte counter=0.
- Reset mid-operation: run drops at the same edge; no PC update. The executor sees run=0 and clears its own state.
- State IDLE: stay while start=0. When start=1, drive MMemory_raddr=pc[ADDR_W-1:0], cnt=0, and go to FETCH.
- State FETCH: 5 cycles.
  - Cycle k (k=0..3) drives raddr=pc+k. Address arithmetic is ADDR_W bits, so 19'h7FFFF+1 wraps to 0.
  - Cycle k+1 captures MMemory_rdata into instr[8k+7:8k].
  - After byte 3 is captured, go to RUN with run=1.
  - Fetch latency from IDLE exit to run high: 5 cycles.
- State RUN: run=1, instr held constant.
  - If PC_decode_wren=1 in any RUN cycle, latch PC_decode_wdata into the redirect register. The last strobe wins.
  - When ok=1: run<=0 and go to RELEASE.
  - If ok and wren are high in the same cycle, that wdata is used.
- State RELEASE: one cycle with run=0, which lets the executor clear ok.
  - pc <= redirect pending ? redirect : pc+4 (32-bit, wraps 32'hFFFF_FFFC -> 0). Clear the redirect latch.
  - If intr was high with ok, go to HALT.
  - Else if start=0, go to IDLE.
  - Else go to FETCH (raddr=new pc).
  - ok must be 0 before the next RUN. If ok is still 1 on entry to RUN, it is ignored for one cycle (guard bit).
- State HALT: halted=1, run=0. Left only by rst.
- start falling during FETCH or RUN: the current instruction completes; the check happens only in RELEASE.
- Instruction throughput without stalls: 5 fetch cycles + executor cycles + 1 RELEASE cycle.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - A cycle counter runs in RUN and resets on entry to RUN.
  - If it reaches TIMEOUT_CYCLES with ok still 0: run<=0, fault<=1 (sticky until rst), go to HALT, pc unchanged.
- Not defined: no counter, fault tied to 0, RUN waits forever.

Decomposition:
- Shared package fetch_pkg:
  - state encoding IDLE/FETCH/RUN/RELEASE/HALT;
  - INSTR_BYTES=4;
  - PC_STEP=32'd4;
  - default RESET_PC.
- One natural sub-module: fetch_watchdog (counter + compare, instantiated only under FETCH_TIMEOUT_EN).
- Byte assembly and PC logic stay inline.

Test Plan:
- Sequential fetch: mem[0..3]=01 02 03 04, start=1 -> raddr 0,1,2,3 on consecutive cycles; run rises with instr=32'h04030201 on the 6th cycle after reset release. Responder ok after 3 cycles -> pc=4, next fetch at raddr=4.
- Redirect: one-cycle wren with wdata=32'h40, two cycles before ok -> after RELEASE pc=32'h40, first raddr=19'h40. A back-to-back run without redirect -> pc=32'h44.
- Simultaneous strobe: wren and ok in the same cycle with wdata=32'h100 -> pc=32'h100. ok held high through RELEASE -> no spurious completion of the next instruction.
- Address wrap: RESET_PC=32'h0007_FFFE -> raddr sequence 7FFFE, 7FFFF, 00000, 00001; pc then 32'h0008_0002.
- Stop and halt: start dropped during RUN -> instruction completes, state IDLE, run stays 0. intr=1 with ok -> halted=1 until rst. rst asserted mid-FETCH -> next cycle all outputs at reset values.
- FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=8 and the responder never asserting ok -> run falls after 8 RUN cycles, fault=1, halted=1, pc unchanged.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch sequencer:
//   state_e          - sequencer state encoding (IDLE/FETCH/RUN/RELEASE/HALT)
//   INSTR_BYTES      - bytes per instruction fetched from byte-wide memory
//   PC_STEP          - sequential PC increment
//   DEFAULT_RESET_PC - default PC after reset
//   BYTE_CNT_W       - width of the fetch byte counter (counts 0..INSTR_BYTES)
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_RUN     = 3'd2,
    ST_RELEASE = 3'd3,
    ST_HALT    = 3'd4
  } state_e;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned BYTE_CNT_W       = $clog2(INSTR_BYTES + 1);

endpackage

// File: rtl/fetch_watchdog.sv
// -----------------------------------------------------------------------------
// fetch_watchdog
// Counts cycles spent in RUN and flags expiry when the executor has not
// answered within TIMEOUT_CYCLES cycles. Only instantiated by fetch_sequencer
// when FETCH_TIMEOUT_EN is defined.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   clear_i   in   restart the count (asserted on the cycle that enters RUN)
//   en_i      in   count this cycle (sequencer is in RUN)
//   expire_o  out  high during the TIMEOUT_CYCLES-th RUN cycle
// -----------------------------------------------------------------------------
module fetch_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of RUN cycles already completed, so the first RUN
  // cycle sees 0 and the last permitted one sees TIMEOUT_CYCLES-1.
  assign expire_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Initiator side of the run/ok instruction handshake. Owns the program
// counter, fetches each 32-bit instruction as four little-endian bytes from
// byte-wide main memory (1-cycle read latency), presents it with run high,
// waits for ok, applies any executor redirect and moves to the next PC.
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   defined   - RUN watchdog; after TIMEOUT_CYCLES without ok the sequencer
//               drops run, sets the sticky fault flag and halts (pc kept).
//   undefined - no watchdog, fault tied low, RUN waits for ok indefinitely.
//
// Ports:
//   clk              in   system clock, rising edge
//   rst              in   synchronous active-high reset
//   start            in   level enable; low stops at next instruction boundary
//   MMemory_raddr    out  byte read address (ADDR_W bits)
//   MMemory_rdata    in   read data for the address registered last cycle
//   instr            out  assembled instruction, stable while run=1
//   run              out  instruction valid / execute request
//   ok               in   executor done; held high until run falls
//   PC_decode_wdata  in   redirect target
//   PC_decode_wren   in   redirect strobe, any cycle while run=1
//   intr             in   halt request, sampled together with ok
//   pc               out  address of the current instruction
//   halted           out  sequencer stopped in HALT
//   fault            out  watchdog expiry flag (sticky until rst)
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int unsigned ADDR_W         = 19,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] MMemory_raddr,
  input  logic [7:0]        MMemory_rdata,
  output logic [31:0]       instr,
  output logic              run,
  input  logic              ok,
  input  logic [31:0]       PC_decode_wdata,
  input  logic              PC_decode_wren,
  input  logic              intr,
  output logic [31:0]       pc,
  output logic              halted,
  output logic              fault
);

  localparam logic [BYTE_CNT_W-1:0] CNT_LAST = BYTE_CNT_W'(INSTR_BYTES);

  state_e                  state_q, state_d;
  logic [31:0]             pc_q, pc_d;
  logic [ADDR_W-1:0]       raddr_q, raddr_d;
  logic [31:0]             instr_q, instr_d;
  logic                    run_q, run_d;
  logic                    halted_q, halted_d;
  logic [31:0]             redir_q, redir_d;
  logic                    redir_vld_q, redir_vld_d;
  logic [BYTE_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    guard_q, guard_d;
  logic                    halt_req_q, halt_req_d;

  logic [31:0]             pc_next;
  logic                    ok_acc;
  logic                    wd_expire;
  logic                    timeout_hit;

  // A pending redirect replaces the sequential step; both wrap at 32 bits.
  assign pc_next = redir_vld_q ? redir_q : pc_q + PC_STEP;

  // guard_q is set when ok was still high in the last FETCH cycle: that ok
  // belongs to the previous instruction and is ignored for one RUN cycle.
  assign ok_acc = ok && !guard_q;

  assign timeout_hit = (state_q == ST_RUN) && !ok_acc && wd_expire;

`ifdef FETCH_TIMEOUT_EN
  logic fault_q, fault_d;

  fetch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear_i ((state_q == ST_FETCH) && (cnt_q == CNT_LAST)),
    .en_i    (state_q == ST_RUN),
    .expire_o(wd_expire)
  );

  assign fault_d = fault_q | timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign wd_expire = 1'b0;
  assign fault     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    raddr_d     = raddr_q;
    instr_d     = instr_q;
    run_d       = run_q;
    halted_d    = halted_q;
    redir_d     = redir_q;
    redir_vld_d = redir_vld_q;
    cnt_d       = cnt_q;
    guard_d     = guard_q;
    halt_req_d  = halt_req_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          raddr_d = pc_q[ADDR_W-1:0];
          cnt_d   = '0;
        end
      end

      // cnt_q=k drives byte address pc+k (k<4); because the memory answers
      // one cycle later, cnt_q=k+1 captures byte k. cnt_q=4 takes the last
      // byte and enters RUN.
      ST_FETCH: begin
        for (int k = 0; k < INSTR_BYTES; k++) begin
          if (cnt_q == BYTE_CNT_W'(k + 1)) begin
            instr_d[8*k +: 8] = MMemory_rdata;
          end
        end
        if (cnt_q < BYTE_CNT_W'(INSTR_BYTES - 1)) begin
          raddr_d = raddr_q + ADDR_W'(1);
        end
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          run_d   = 1'b1;
          guard_d = ok;
        end else begin
          cnt_d = cnt_q + BYTE_CNT_W'(1);
        end
      end

      ST_RUN: begin
        guard_d = 1'b0;
        // Latched even in the ok cycle, so a same-cycle strobe still counts.
        if (PC_decode_wren) begin
          redir_d     = PC_decode_wdata;
          redir_vld_d = 1'b1;
        end
        if (ok_acc) begin
          run_d      = 1'b0;
          halt_req_d = intr;
          state_d    = ST_RELEASE;
        end else if (timeout_hit) begin
          run_d    = 1'b0;
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end
      end

      // One run=0 cycle so the executor can drop ok; the start level is only
      // looked at here, so a falling start never cuts an instruction short.
      ST_RELEASE: begin
        pc_d        = pc_next;
        redir_vld_d = 1'b0;
        halt_req_d  = 1'b0;
        if (halt_req_q) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else if (!start) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FETCH;
          raddr_d = pc_next[ADDR_W-1:0];
          cnt_d   = '0;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      raddr_q     <= '0;
      instr_q     <= '0;
      run_q       <= 1'b0;
      halted_q    <= 1'b0;
      redir_q     <= '0;
      redir_vld_q <= 1'b0;
      cnt_q       <= '0;
      guard_q     <= 1'b0;
      halt_req_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      raddr_q     <= raddr_d;
      instr_q     <= instr_d;
      run_q       <= run_d;
      halted_q    <= halted_d;
      redir_q     <= redir_d;
      redir_vld_q <= redir_vld_d;
      cnt_q       <= cnt_d;
      guard_q     <= guard_d;
      halt_req_q  <= halt_req_d;
    end
  end

  assign MMemory_raddr = raddr_q;
  assign instr         = instr_q;
  assign run           = run_q;
  assign pc            = pc_q;
  assign halted        = halted_q;

endmodule
